// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM: sequences fetch, decode and per-class
// execute/memory/writeback states and drives the datapath control lines.
module multicycle_control #(
   parameter bit MEM_WAIT_EN = 1'b1
) (
   input  logic       CLK,
   input  logic       RST_n,
   input  logic [5:0] Op,
   input  logic [5:0] Funct,
   input  logic       MemReady,
   input  logic       Zero,
   output logic       PCWrite,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUOp,
   output logic [1:0] ALUSrcB,
   output logic [1:0] PCSource,
   output logic [1:0] RegDst,
   output logic [1:0] MemtoReg,
   output logic       Illegal,
   output logic [3:0] State
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] FN_JR    = 6'b001000;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_RTEXE  = 4'd6,
      S_RTWB   = 4'd7,
      S_BEQ    = 4'd8,
      S_JUMP   = 4'd9,
      S_ADDIEX = 4'd10,
      S_ADDIWB = 4'd11,
      S_JAL    = 4'd12,
      S_JR     = 4'd13,
      S_HALT   = 4'd14
   } state_e;

   state_e state_q, state_d;
   logic   illegal_q, illegal_d;
   logic   mem_rdy;

   // With waiting disabled, memory accesses always complete in one cycle.
   assign mem_rdy = MEM_WAIT_EN ? MemReady : 1'b1;

   // State and sticky illegal-opcode flag registers.
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         state_q   <= S_FETCH;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end
   end

   // Next-state logic; HALT (and the unused code) is absorbing until reset.
   always_comb begin
      state_d   = state_q;
      illegal_d = illegal_q;
      case (state_q)
         S_FETCH:  if (mem_rdy) state_d = S_DECODE;
         S_DECODE: begin
            case (Op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = (Funct == FN_JR) ? S_JR : S_RTEXE;
               OP_BEQ:       state_d = S_BEQ;
               OP_J:         state_d = S_JUMP;
               OP_JAL:       state_d = S_JAL;
               OP_ADDI:      state_d = S_ADDIEX;
               default:      state_d = S_HALT;
            endcase
         end
         S_MEMADR: state_d = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  if (mem_rdy) state_d = S_MEMWB;
         S_MEMWB:  state_d = S_FETCH;
         S_MEMWR:  if (mem_rdy) state_d = S_FETCH;
         S_RTEXE:  state_d = S_RTWB;
         S_RTWB:   state_d = S_FETCH;
         S_BEQ:    state_d = S_FETCH;
         S_JUMP:   state_d = S_FETCH;
         S_ADDIEX: state_d = S_ADDIWB;
         S_ADDIWB: state_d = S_FETCH;
         S_JAL:    state_d = S_FETCH;
         S_JR:     state_d = S_FETCH;
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_HALT;
      endcase
      if (state_d == S_HALT) illegal_d = 1'b1;
   end

   // Control decode per state; everything is forced low while reset is held.
   always_comb begin
      PCWrite  = 1'b0;
      IorD     = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      ALUSrcA  = 1'b0;
      ALUOp    = 2'b00;
      ALUSrcB  = 2'b00;
      PCSource = 2'b00;
      RegDst   = 2'b00;
      MemtoReg = 2'b00;
      if (RST_n) begin
         case (state_q)
            S_FETCH: begin
               MemRead = 1'b1;
               ALUSrcB = 2'b01;
               IRWrite = mem_rdy;
               PCWrite = mem_rdy;
            end
            S_DECODE: ALUSrcB = 2'b11;
            S_MEMADR: begin
               ALUSrcA = 1'b1;
               ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
               MemRead = 1'b1;
               IorD    = 1'b1;
            end
            S_MEMWB: begin
               RegWrite = 1'b1;
               MemtoReg = 2'b01;
            end
            S_MEMWR: begin
               MemWrite = 1'b1;
               IorD     = 1'b1;
            end
            S_RTEXE: begin
               ALUSrcA = 1'b1;
               ALUOp   = 2'b10;
            end
            S_RTWB: begin
               RegWrite = 1'b1;
               RegDst   = 2'b01;
            end
            S_BEQ: begin
               ALUSrcA  = 1'b1;
               ALUOp    = 2'b01;
               PCSource = 2'b01;
               PCWrite  = Zero;
            end
            S_JUMP: begin
               PCWrite  = 1'b1;
               PCSource = 2'b10;
            end
            S_ADDIEX: begin
               ALUSrcA = 1'b1;
               ALUSrcB = 2'b10;
            end
            S_ADDIWB: RegWrite = 1'b1;
            S_JAL: begin
               RegWrite = 1'b1;
               RegDst   = 2'b10;
               MemtoReg = 2'b10;
               PCWrite  = 1'b1;
               PCSource = 2'b10;
            end
            S_JR: begin
               PCWrite  = 1'b1;
               PCSource = 2'b11;
            end
            default: ;
         endcase
      end
   end

   assign Illegal = illegal_q;
   assign State   = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: instruction vector table,
// hand-written wait/halt/reset sequences and a randomized run against a
// path-based reference model.
module tb_multicycle_control;

   logic       clk, rst_n;
   logic [5:0] op, funct;
   logic       mem_ready, zero;
   logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA;
   logic [1:0] ALUOp, ALUSrcB, PCSource, RegDst, MemtoReg;
   logic       Illegal;
   logic [3:0] State;

   multicycle_control dut (
      .CLK(clk), .RST_n(rst_n), .Op(op), .Funct(funct),
      .MemReady(mem_ready), .Zero(zero),
      .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
      .IRWrite(IRWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
      .ALUOp(ALUOp), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
      .RegDst(RegDst), .MemtoReg(MemtoReg), .Illegal(Illegal), .State(State)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       pcw, iord, mrd, mwr, irw, rw, asa;
      logic [1:0] aluop, srcb, pcsrc, regdst, m2r;
      logic       ill;
      logic [3:0] st;
   } cw_t;

   cw_t dut_w;
   assign dut_w = {PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA,
                   ALUOp, ALUSrcB, PCSource, RegDst, MemtoReg, Illegal, State};

   int total = 0;
   int bad   = 0;
   int path_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expected control word for a numbered step given this cycle's MemReady and Zero.
   function automatic cw_t exp_word(input int s, input logic mr, input logic z);
      cw_t w;
      w = '0;
      w.st = 4'(s);
      case (s)
         0:  begin w.mrd = 1'b1; w.srcb = 2'b01; w.pcw = mr; w.irw = mr; end
         1:  w.srcb = 2'b11;
         2:  begin w.asa = 1'b1; w.srcb = 2'b10; end
         3:  begin w.mrd = 1'b1; w.iord = 1'b1; end
         4:  begin w.rw = 1'b1; w.m2r = 2'b01; end
         5:  begin w.mwr = 1'b1; w.iord = 1'b1; end
         6:  begin w.asa = 1'b1; w.aluop = 2'b10; end
         7:  begin w.rw = 1'b1; w.regdst = 2'b01; end
         8:  begin w.asa = 1'b1; w.aluop = 2'b01; w.pcsrc = 2'b01; w.pcw = z; end
         9:  begin w.pcw = 1'b1; w.pcsrc = 2'b10; end
         10: begin w.asa = 1'b1; w.srcb = 2'b10; end
         11: w.rw = 1'b1;
         12: begin w.rw = 1'b1; w.regdst = 2'b10; w.m2r = 2'b10; w.pcw = 1'b1; w.pcsrc = 2'b10; end
         13: begin w.pcw = 1'b1; w.pcsrc = 2'b11; end
         default: w.ill = 1'b1;
      endcase
      return w;
   endfunction

   // Sequence of steps an instruction walks through, from its fetch onward.
   function automatic void load_path(input logic [5:0] o, input logic [5:0] f);
      case (o)
         6'b100011: path_q = {0, 1, 2, 3, 4};
         6'b101011: path_q = {0, 1, 2, 5};
         6'b000000: if (f == 6'b001000) path_q = {0, 1, 13}; else path_q = {0, 1, 6, 7};
         6'b000100: path_q = {0, 1, 8};
         6'b000010: path_q = {0, 1, 9};
         6'b000011: path_q = {0, 1, 12};
         6'b001000: path_q = {0, 1, 10, 11};
         default:   path_q = {0, 1, 14};
      endcase
   endfunction

   function automatic bit is_mem_wait(input int s);
      return (s == 0) || (s == 3) || (s == 5);
   endfunction

   // Called just after a rising edge; leaves the DUT in FETCH for the next edge.
   task automatic do_reset();
      rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b0; op = '0; funct = '0;
      #1 chk("reset_outputs", 32'(dut_w), 32'(0));
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   typedef struct {
      logic [5:0]  op;
      logic [5:0]  funct;
      logic        zero;
      int          n;
      logic [23:0] states;
      logic [7:0]  rw, pcw, mw;
   } vec_t;

   vec_t tbl[10];

   task automatic pick_instr();
      int k;
      logic [5:0] ops[8];
      ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000000,
              6'b000100, 6'b000010, 6'b000011, 6'b001000};
      k = $urandom_range(0, 7);
      op = ops[k];
      funct = 6'($urandom);
      if (k == 3) funct = 6'b001000;
      load_path(op, funct);
   endtask

   initial begin
      int mw_cnt, rw_cnt, fetch_at4;
      vec_t v;

      tbl[0] = '{6'b100011, 6'd0,       1'b0, 5, 24'h043210, 8'h10, 8'h01, 8'h00};
      tbl[1] = '{6'b101011, 6'd0,       1'b0, 4, 24'h005210, 8'h00, 8'h01, 8'h08};
      tbl[2] = '{6'b000000, 6'b100000,  1'b0, 4, 24'h007610, 8'h08, 8'h01, 8'h00};
      tbl[3] = '{6'b001000, 6'd0,       1'b0, 4, 24'h00BA10, 8'h08, 8'h01, 8'h00};
      tbl[4] = '{6'b000100, 6'd0,       1'b0, 3, 24'h000810, 8'h00, 8'h01, 8'h00};
      tbl[5] = '{6'b000100, 6'd0,       1'b1, 3, 24'h000810, 8'h00, 8'h05, 8'h00};
      tbl[6] = '{6'b000010, 6'd0,       1'b0, 3, 24'h000910, 8'h00, 8'h05, 8'h00};
      tbl[7] = '{6'b000011, 6'd0,       1'b0, 3, 24'h000C10, 8'h04, 8'h05, 8'h00};
      tbl[8] = '{6'b000000, 6'b001000,  1'b0, 3, 24'h000D10, 8'h00, 8'h05, 8'h00};
      tbl[9] = '{6'b000000, 6'b001000,  1'b1, 3, 24'h000D10, 8'h00, 8'h05, 8'h00};

      rst_n = 1'b0; mem_ready = 1'b0; zero = 1'b0; op = '0; funct = '0;
      #1 chk("reset_before_clock", 32'(dut_w), 32'(0));
      @(posedge clk);
      do_reset();

      // Instruction table with memory always ready.
      for (int i = 0; i < 10; i++) begin
         v = tbl[i];
         op = v.op; funct = v.funct; zero = v.zero; mem_ready = 1'b1;
         for (int c = 0; c < v.n; c++) begin
            @(negedge clk);
            chk($sformatf("tbl%0d_state_c%0d", i, c), 32'(State), 32'(v.states[4*c +: 4]));
            chk($sformatf("tbl%0d_regwrite_c%0d", i, c), 32'(RegWrite), 32'(v.rw[c]));
            chk($sformatf("tbl%0d_pcwrite_c%0d", i, c), 32'(PCWrite), 32'(v.pcw[c]));
            chk($sformatf("tbl%0d_memwrite_c%0d", i, c), 32'(MemWrite), 32'(v.mw[c]));
            chk($sformatf("tbl%0d_word_c%0d", i, c), 32'(dut_w),
                32'(exp_word(int'(v.states[4*c +: 4]), 1'b1, v.zero)));
            @(posedge clk); #1;
         end
      end

      // sw with MemReady low for three cycles in the write state.
      do_reset();
      op = 6'b101011; funct = '0; mem_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      mw_cnt = 0; rw_cnt = 0; fetch_at4 = 0;
      for (int i = 0; i < 6; i++) begin
         mem_ready = (i >= 3);
         @(negedge clk);
         mw_cnt += int'(MemWrite);
         rw_cnt += int'(RegWrite);
         if (i == 4 && State == 4'd0) fetch_at4 = 1;
         if (i == 5) chk("sw_after_exit_state", 32'(State), 32'(1));
         @(posedge clk); #1;
      end
      chk("sw_memwrite_cycles", 32'(mw_cnt), 32'(4));
      chk("sw_no_regwrite", 32'(rw_cnt), 32'(0));
      chk("sw_exit_to_fetch", 32'(fetch_at4), 32'(1));

      // Undecoded opcode parks in HALT with Illegal set until reset.
      do_reset();
      op = 6'b111111; mem_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 20; i++) begin
         mem_ready = 1'($urandom); zero = 1'($urandom);
         @(negedge clk);
         chk($sformatf("halt_word_%0d", i), 32'(dut_w), 32'(exp_word(14, mem_ready, zero)));
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1 chk("halt_reset_state", 32'({Illegal, State}), 32'(0));
      @(posedge clk); #1 rst_n = 1'b1; mem_ready = 1'b1; op = '0;
      @(negedge clk);
      chk("halt_released_fetch", 32'(dut_w), 32'(exp_word(0, 1'b1, zero)));
      @(posedge clk); #1;

      // Reset asserted while waiting in the memory-read state.
      do_reset();
      op = 6'b100011; mem_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 mem_ready = 1'b0;
      @(negedge clk);
      chk("memrd_wait_word", 32'(dut_w), 32'(exp_word(3, 1'b0, zero)));
      #2 rst_n = 1'b0;
      #1 chk("memrd_reset_immediate", 32'(dut_w), 32'(0));
      @(posedge clk); #1;
      chk("memrd_reset_held", 32'(dut_w), 32'(0));
      @(negedge clk); rst_n = 1'b1; mem_ready = 1'b1;
      #1 chk("memrd_release_fetch", 32'(dut_w), 32'(exp_word(0, 1'b1, zero)));
      @(negedge clk);
      chk("memrd_release_decode", 32'(dut_w), 32'(exp_word(1, 1'b1, zero)));
      @(posedge clk);

      // Randomized instruction stream with random memory stalls.
      do_reset();
      pick_instr();
      for (int c = 0; c < 800; c++) begin
         mem_ready = ($urandom_range(0, 3) != 0);
         zero = 1'($urandom);
         @(negedge clk);
         chk($sformatf("rand_c%0d", c), 32'(dut_w), 32'(exp_word(path_q[0], mem_ready, zero)));
         @(posedge clk);
         if (!(is_mem_wait(path_q[0]) && !mem_ready)) void'(path_q.pop_front());
         if (path_q.size() == 0) pick_instr();
         #1;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
